// File: rtl/regfile_write_arbiter_pkg.sv
// rfarb_pkg: shared types and helpers for regfile_write_arbiter.
//   rfarb_state_t     - arbiter FSM state (IDLE, PEND, FORCE)
//   starve_cnt_width  - starve counter width for a given STARVE_MAX,
//                       sized to hold 0..STARVE_MAX
package rfarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // debug buffer empty
        PEND  = 2'd1,   // buffer full, waiting for a free write-port cycle
        FORCE = 2'd2    // buffer full, writeback stalled for one cycle
    } rfarb_state_t;

    function automatic int unsigned starve_cnt_width(input int unsigned starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port (WE3/A3/WD3) between the
//   pipeline writeback stage and a debug/host write requester. Writeback has
//   priority and passes through combinationally. A debug write is held in a
//   one-entry buffer and issued in the first cycle writeback leaves free.
//
//   Optional feature macro: RFARB_STARVE_GUARD_EN
//     defined   - after STARVE_MAX lost cycles the pending debug write is
//                 forced through, stalling writeback for exactly one cycle.
//     undefined - no starve counter; stall_wb is tied low and a pending
//                 debug write waits for a cycle with no writeback write.
//
// Ports
//   CLK, RST_N          clock (rising edge), async active-low reset
//   wb_we/addr/data     writeback write request (x0 writes are dropped)
//   dbg_valid/addr/data debug write request; dbg_ready = buffer empty
//   stall_wb            writeback must hold its request this cycle
//   WE3, A3, WD3        register file write port
//   dbg_wr_cnt          completed debug writes, wraps
module regfile_write_arbiter
    import rfarb_pkg::*;
#(
    parameter int unsigned A_WIDTH    = 5,
    parameter int unsigned D_WIDTH    = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 wb_we,
    input  logic [A_WIDTH-1:0]   wb_addr,
    input  logic [D_WIDTH-1:0]   wb_data,
    input  logic                 dbg_valid,
    output logic                 dbg_ready,
    input  logic [A_WIDTH-1:0]   dbg_addr,
    input  logic [D_WIDTH-1:0]   dbg_data,
    output logic                 stall_wb,
    output logic                 WE3,
    output logic [A_WIDTH-1:0]   A3,
    output logic [D_WIDTH-1:0]   WD3,
    output logic [CNT_WIDTH-1:0] dbg_wr_cnt
);

    if (STARVE_MAX < 1) begin : g_starve_max_check
        $error("STARVE_MAX must be at least 1");
    end

    rfarb_state_t         state_q, state_d;
    logic [A_WIDTH-1:0]   buf_addr_q, buf_addr_d;
    logic [D_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

`ifdef RFARB_STARVE_GUARD_EN
    localparam int unsigned SW = starve_cnt_width(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;
`endif

    logic wb_slot;
    logic we_raw;

    // Writes to x0 are architecturally discarded, so they never claim the port.
    assign wb_slot = wb_we & (wb_addr != '0);

    always_comb begin
        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        we_raw     = 1'b0;
        A3         = wb_addr;
        WD3        = wb_data;
`ifdef RFARB_STARVE_GUARD_EN
        starve_d   = starve_q;
`endif
        case (state_q)
            IDLE: begin
                we_raw = wb_slot;
                if (dbg_valid) begin
                    buf_addr_d = dbg_addr;
                    buf_data_d = dbg_data;
`ifdef RFARB_STARVE_GUARD_EN
                    starve_d   = '0;
`endif
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (wb_slot) begin
                    we_raw = 1'b1;
`ifdef RFARB_STARVE_GUARD_EN
                    // Checked before the increment: STARVE_MAX lost cycles in total.
                    if (starve_q == SW'(STARVE_MAX - 1)) begin
                        state_d = FORCE;
                    end
                    starve_d = starve_q + 1'b1;
`endif
                end else begin
                    we_raw  = (buf_addr_q != '0);
                    A3      = buf_addr_q;
                    WD3     = buf_data_q;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef RFARB_STARVE_GUARD_EN
            FORCE: begin
                // Writeback is stalled, so its request is ignored this cycle.
                we_raw  = (buf_addr_q != '0);
                A3      = buf_addr_q;
                WD3     = buf_data_q;
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The writeback path is combinational, so gate it while reset is held.
    assign WE3        = we_raw & RST_N;
    assign dbg_ready  = (state_q == IDLE);
    assign dbg_wr_cnt = cnt_q;
`ifdef RFARB_STARVE_GUARD_EN
    assign stall_wb   = (state_q == FORCE);
`else
    assign stall_wb   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef RFARB_STARVE_GUARD_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed
// by randomized traffic, all checked against a behavioural model that tracks
// the pending debug write and the number of cycles it has lost to writeback.
module tb_regfile_write_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned SM = 4;
    localparam int unsigned CW = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          dbg_valid;
    logic          dbg_ready;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          stall_wb;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [CW-1:0] dbg_wr_cnt;

    regfile_write_arbiter #(
        .A_WIDTH(AW),
        .D_WIDTH(DW),
        .STARVE_MAX(SM),
        .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .wb_we(wb_we),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .stall_wb(stall_wb),
        .WE3(WE3),
        .A3(A3),
        .WD3(WD3),
        .dbg_wr_cnt(dbg_wr_cnt)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: one outstanding debug write, cycles it has lost, and
    // the completed-write count modulo 2^CW.
    bit            m_full;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_lost;
    int            m_cnt;
    int            stall_seen;

    task automatic model_reset();
        m_full = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_lost = 0;
        m_cnt  = 0;
    endtask

    // Drive one cycle of stimulus, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bit            wb_ok;
        bit            drain;
        bit            force_now;
        bit            exp_we;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        dbg_valid = dv;
        dbg_addr  = da;
        dbg_data  = dd;
        @(negedge CLK);
        wb_ok     = we && (wa != '0);
        force_now = 1'b0;
        drain     = 1'b0;
        if (!m_full) begin
            exp_we = wb_ok;
            ea     = wa;
            ed     = wd;
        end else begin
`ifdef RFARB_STARVE_GUARD_EN
            force_now = (m_lost >= int'(SM));
`endif
            if (force_now || !wb_ok) begin
                drain  = 1'b1;
                exp_we = (m_addr != '0);
                ea     = m_addr;
                ed     = m_data;
            end else begin
                exp_we = 1'b1;
                ea     = wa;
                ed     = wd;
            end
        end
        chk("WE3", 64'(WE3), 64'(exp_we));
        if (exp_we) begin
            chk("A3", 64'(A3), 64'(ea));
            chk("WD3", 64'(WD3), 64'(ed));
        end
        chk("dbg_ready", 64'(dbg_ready), 64'(!m_full));
        chk("stall_wb", 64'(stall_wb), 64'(force_now));
        chk("dbg_wr_cnt", 64'(dbg_wr_cnt), 64'(m_cnt));
        if (stall_wb) stall_seen++;
        if (m_full) begin
            if (drain) begin
                m_full = 1'b0;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end else begin
                m_lost++;
            end
        end else if (dv) begin
            m_full = 1'b1;
            m_addr = da;
            m_data = dd;
            m_lost = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int pct;
        RST_N     = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        dbg_valid = 1'b0;
        dbg_addr  = '0;
        dbg_data  = '0;
        model_reset();

        // Reset state, with a writeback request present that must be blocked.
        repeat (2) @(posedge CLK);
        #1;
        wb_we   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'hA5;
        @(negedge CLK);
        chk("rst_WE3", 64'(WE3), 64'd0);
        chk("rst_dbg_ready", 64'(dbg_ready), 64'd1);
        chk("rst_stall_wb", 64'(stall_wb), 64'd0);
        chk("rst_dbg_wr_cnt", 64'(dbg_wr_cnt), 64'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Zero-latency writeback pass-through.
        cycle(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 32'h0);

        // Debug write in an idle port.
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("dbg_cnt_first", 64'(dbg_wr_cnt), 64'd1);

        // Continuous writeback to x1 while a debug write is pending.
        stall_seen = 0;
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'hBEEF);
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'd1, 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0);
`ifdef RFARB_STARVE_GUARD_EN
        chk("stall_count", 64'(stall_seen), 64'd1);
`else
        chk("stall_count", 64'(stall_seen), 64'd0);
`endif
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("dbg_cnt_starve", 64'(dbg_wr_cnt), 64'd2);

        // Debug write to x0 alongside writeback to x0.
        cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h77);
        cycle(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'h0);
        cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("dbg_cnt_x0", 64'(dbg_wr_cnt), 64'd3);

        // Reset pulsed while a debug write is pending.
        cycle(1'b1, 5'd1, 32'h21, 1'b1, 5'd12, 32'hCAFE);
        cycle(1'b1, 5'd1, 32'h22, 1'b0, 5'd0, 32'h0);
        RST_N   = 1'b0;
        wb_we   = 1'b1;
        wb_addr = 5'd2;
        #2;
        chk("midrst_WE3", 64'(WE3), 64'd0);
        chk("midrst_dbg_ready", 64'(dbg_ready), 64'd1);
        chk("midrst_dbg_wr_cnt", 64'(dbg_wr_cnt), 64'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
        repeat (3) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Randomized traffic: heavy writeback first to provoke starvation.
        for (int i = 0; i < 600; i++) begin
            pct = (i < 300) ? 92 : 60;
            cycle(($urandom_range(99) < pct) ? 1'b1 : 1'b0,
                  AW'($urandom_range(7)), DW'($urandom),
                  ($urandom_range(1) == 1) ? 1'b1 : 1'b0,
                  AW'($urandom_range(7)), DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
